// File: rtl/energy_level_tracker.sv
// Saturating energy reserve counter with enable prescalers, one-shot drains,
// a hysteretic 2-bit band indicator and bound-reached pulses.
module energy_level_tracker #(
    parameter int WIDTH       = 8,
    parameter int INC_DIV     = 4,
    parameter int DEC_DIV     = 16,
    parameter int DRAIN_STEP  = 16,
    parameter int TH_LOW      = 64,
    parameter int TH_MID      = 128,
    parameter int TH_HIGH     = 224,
    parameter int HYST        = 8,
    parameter int RESET_LEVEL = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_inc,
    input  logic             en_dec,
    input  logic             drain,
    output logic [WIDTH-1:0] energy_level,
    output logic [1:0]       energy_indicator,
    output logic             depleted,
    output logic             replenished
);

    localparam int IW = (INC_DIV > 1) ? $clog2(INC_DIV) : 1;
    localparam int DW = (DEC_DIV > 1) ? $clog2(DEC_DIV) : 1;
    localparam int SW = WIDTH + 2;

    localparam logic [WIDTH-1:0]        LVL_MAX  = '1;
    localparam logic [WIDTH-1:0]        LVL_RST  = WIDTH'(RESET_LEVEL);
    localparam logic [IW-1:0]           INC_LAST = IW'(INC_DIV - 1);
    localparam logic [DW-1:0]           DEC_LAST = DW'(DEC_DIV - 1);
    localparam logic signed [SW-1:0]    STEP_ONE = SW'(1);
    localparam logic signed [SW-1:0]    STEP_DRN = SW'(DRAIN_STEP);

    localparam logic [WIDTH-1:0] UP_LOW  = WIDTH'(TH_LOW);
    localparam logic [WIDTH-1:0] UP_MID  = WIDTH'(TH_MID);
    localparam logic [WIDTH-1:0] UP_HIGH = WIDTH'(TH_HIGH);
    localparam logic [WIDTH-1:0] DN_LOW  = WIDTH'(TH_LOW - HYST);
    localparam logic [WIDTH-1:0] DN_MID  = WIDTH'(TH_MID - HYST);
    localparam logic [WIDTH-1:0] DN_HIGH = WIDTH'(TH_HIGH - HYST);

    typedef enum logic [1:0] {
        BAND_EMPTY = 2'd0,
        BAND_LOW   = 2'd1,
        BAND_MID   = 2'd2,
        BAND_FULL  = 2'd3
    } band_t;

    // Clamp the widened signed sum back into [0, 2^WIDTH-1].
    function automatic logic [WIDTH-1:0] sat_level(input logic signed [SW-1:0] v);
        if (v[SW-1])
            return '0;
        else if (v > $signed({2'b00, LVL_MAX}))
            return LVL_MAX;
        else
            return v[WIDTH-1:0];
    endfunction

    logic [IW-1:0]        inc_cnt_q, inc_cnt_d;
    logic [DW-1:0]        dec_cnt_q, dec_cnt_d;
    logic                 inc_tick, dec_tick;
    logic [WIDTH-1:0]     level_q, level_d;
    logic signed [SW-1:0] lvl_sum;
    logic                 depleted_q, depleted_d;
    logic                 replenished_q, replenished_d;
    band_t                band_q, band_d;

    // A prescaler only runs while its enable is the sole one asserted.
    always_comb begin
        inc_cnt_d = '0;
        inc_tick  = 1'b0;
        if (en_inc && !en_dec) begin
            if (inc_cnt_q == INC_LAST)
                inc_tick = 1'b1;
            else
                inc_cnt_d = inc_cnt_q + 1'b1;
        end
    end

    always_comb begin
        dec_cnt_d = '0;
        dec_tick  = 1'b0;
        if (en_dec && !en_inc) begin
            if (dec_cnt_q == DEC_LAST)
                dec_tick = 1'b1;
            else
                dec_cnt_d = dec_cnt_q + 1'b1;
        end
    end

    always_comb begin
        lvl_sum = $signed({2'b00, level_q});
        if (inc_tick)
            lvl_sum = lvl_sum + STEP_ONE;
        if (dec_tick)
            lvl_sum = lvl_sum - STEP_ONE;
        if (drain)
            lvl_sum = lvl_sum - STEP_DRN;
        level_d       = sat_level(lvl_sum);
        depleted_d    = (level_d == '0) && (level_q != '0);
        replenished_d = (level_d == LVL_MAX) && (level_q != LVL_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_cnt_q     <= '0;
            dec_cnt_q     <= '0;
            level_q       <= LVL_RST;
            depleted_q    <= 1'b0;
            replenished_q <= 1'b0;
        end else begin
            inc_cnt_q     <= inc_cnt_d;
            dec_cnt_q     <= dec_cnt_d;
            level_q       <= level_d;
            depleted_q    <= depleted_d;
            replenished_q <= replenished_d;
        end
    end

    // Band FSM follows the registered level, one band per cycle at most.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            band_q <= BAND_MID;
        else
            band_q <= band_d;
    end

    always_comb begin
        band_d = band_q;
        case (band_q)
            BAND_EMPTY: begin
                if (level_q >= UP_LOW)
                    band_d = BAND_LOW;
            end
            BAND_LOW: begin
                if (level_q >= UP_MID)
                    band_d = BAND_MID;
                else if (level_q < DN_LOW)
                    band_d = BAND_EMPTY;
            end
            BAND_MID: begin
                if (level_q >= UP_HIGH)
                    band_d = BAND_FULL;
                else if (level_q < DN_MID)
                    band_d = BAND_LOW;
            end
            BAND_FULL: begin
                if (level_q < DN_HIGH)
                    band_d = BAND_MID;
            end
            default: band_d = BAND_MID;
        endcase
    end

    always_comb begin
        energy_indicator = band_q;
    end

    assign energy_level = level_q;
    assign depleted     = depleted_q;
    assign replenished  = replenished_q;

endmodule

// File: tb/tb_energy_level_tracker.sv
// Bench for energy_level_tracker: scenario table, reset corner case and
// randomized traffic against a run-length based reference model.
module tb_energy_level_tracker;

    localparam int INC_DIV    = 4;
    localparam int DEC_DIV    = 16;
    localparam int DRAIN_STEP = 16;
    localparam int LMAX       = 255;
    localparam int HYST       = 8;

    logic       clk = 1'b0;
    logic       rst, en_inc, en_dec, drain;
    logic [7:0] energy_level;
    logic [1:0] energy_indicator;
    logic       depleted, replenished;

    energy_level_tracker dut (
        .clk              (clk),
        .rst              (rst),
        .en_inc           (en_inc),
        .en_dec           (en_dec),
        .drain            (drain),
        .energy_level     (energy_level),
        .energy_indicator (energy_indicator),
        .depleted         (depleted),
        .replenished      (replenished)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int m_lvl, m_band, m_irun, m_drun, m_dep, m_rep;
    int up_th[3] = '{64, 128, 224};
    int seg_dep, seg_rep;

    typedef struct {
        logic inc;
        logic dec;
        logic drn;
        int   cycles;
        int   lvl;
        int   band;
        int   dep_n;
        int   rep_n;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 128;
        m_band = 2;
        m_irun = 0;
        m_drun = 0;
        m_dep  = 0;
        m_rep  = 0;
    endtask

    // Ticks fire on every INC_DIV-th / DEC_DIV-th cycle of an uninterrupted exclusive run.
    task automatic model_edge();
        int nl, it, dt;
        m_irun = (en_inc && !en_dec) ? m_irun + 1 : 0;
        m_drun = (en_dec && !en_inc) ? m_drun + 1 : 0;
        it = (m_irun > 0 && (m_irun % INC_DIV) == 0) ? 1 : 0;
        dt = (m_drun > 0 && (m_drun % DEC_DIV) == 0) ? 1 : 0;
        nl = m_lvl + it - dt - (drain ? DRAIN_STEP : 0);
        if (nl < 0)    nl = 0;
        if (nl > LMAX) nl = LMAX;
        if (m_band < 3 && m_lvl >= up_th[m_band])
            m_band = m_band + 1;
        else if (m_band > 0 && m_lvl < up_th[m_band-1] - HYST)
            m_band = m_band - 1;
        m_dep = (nl == 0 && m_lvl != 0) ? 1 : 0;
        m_rep = (nl == LMAX && m_lvl != LMAX) ? 1 : 0;
        m_lvl = nl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        tests++;
        if (int'(energy_level) != m_lvl || int'(energy_indicator) != m_band ||
            int'(depleted) != m_dep || int'(replenished) != m_rep) begin
            fails++;
            $display("FAIL model: got lvl=%0d band=%0d dep=%0d rep=%0d, expected lvl=%0d band=%0d dep=%0d rep=%0d",
                     energy_level, energy_indicator, depleted, replenished,
                     m_lvl, m_band, m_dep, m_rep);
        end
        seg_dep += int'(depleted);
        seg_rep += int'(replenished);
    endtask

    task automatic async_reset_check();
        #1;
        rst = 1'b1;
        #1;
        check("rst_level", int'(energy_level), 128);
        check("rst_band",  int'(energy_indicator), 2);
        check("rst_dep",   int'(depleted), 0);
        check("rst_rep",   int'(replenished), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int mode, len;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 100, 153, 2, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 284, 224, 2, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,   1, 224, 3, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 123, 255, 3, 0, 1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  20, 255, 3, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1,   8, 127, 2, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0,  12, 130, 2, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 160, 120, 2, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  16, 119, 2, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0,   1, 119, 1, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0,  24, 125, 1, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0,  12, 128, 1, 0, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b0,   1, 128, 2, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b0,  50, 128, 2, 0, 0};
        vecs[14] = '{1'b1, 1'b0, 1'b0,   3, 128, 2, 0, 0};
        vecs[15] = '{1'b1, 1'b0, 1'b0,   1, 129, 2, 0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b1,   5,  49, 1, 0, 0};
        vecs[17] = '{1'b0, 1'b0, 1'b1,   4,   0, 0, 1, 0};
        vecs[18] = '{1'b0, 1'b0, 1'b1,   2,   0, 0, 0, 0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 160,  40, 0, 0, 0};
        vecs[20] = '{1'b0, 1'b0, 1'b1,   2,   8, 0, 0, 0};
        vecs[21] = '{1'b0, 1'b0, 1'b1,   1,   0, 0, 1, 0};

        rst    = 1'b1;
        en_inc = 1'b0;
        en_dec = 1'b0;
        drain  = 1'b0;
        model_reset();
        #2;
        check("init_level", int'(energy_level), 128);
        check("init_band",  int'(energy_indicator), 2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenario table, applied back to back from reset.
        for (int i = 0; i < 22; i++) begin
            en_inc  = vecs[i].inc;
            en_dec  = vecs[i].dec;
            drain   = vecs[i].drn;
            seg_dep = 0;
            seg_rep = 0;
            repeat (vecs[i].cycles) step();
            check($sformatf("vec%0d_level", i), int'(energy_level), vecs[i].lvl);
            check($sformatf("vec%0d_band", i), int'(energy_indicator), vecs[i].band);
            check($sformatf("vec%0d_dep_pulses", i), seg_dep, vecs[i].dep_n);
            check($sformatf("vec%0d_rep_pulses", i), seg_rep, vecs[i].rep_n);
        end

        // Mid-run reset with a partial prescaler count: level 40, inc_cnt 2.
        en_inc = 1'b1;
        en_dec = 1'b0;
        drain  = 1'b0;
        repeat (162) step();
        check("pre_rst_level", int'(energy_level), 40);
        async_reset_check();
        repeat (3) step();
        check("post_rst_no_step", int'(energy_level), 128);
        step();
        check("post_rst_first_step", int'(energy_level), 129);

        // Randomized traffic in runs of a random mode.
        for (int r = 0; r < 120; r++) begin
            mode = $urandom_range(0, 5);
            len  = $urandom_range(1, 60);
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0: begin en_inc = 1'b1; en_dec = 1'b0; drain = 1'b0; end
                    1: begin en_inc = 1'b0; en_dec = 1'b1; drain = 1'b0; end
                    2: begin en_inc = 1'b1; en_dec = 1'b1; drain = ($urandom_range(0, 7) == 0); end
                    3: begin en_inc = 1'b0; en_dec = 1'b0; drain = $urandom_range(0, 1); end
                    4: begin en_inc = 1'b1; en_dec = 1'b0; drain = ($urandom_range(0, 15) == 0); end
                    default: begin
                        en_inc = $urandom_range(0, 1);
                        en_dec = $urandom_range(0, 1);
                        drain  = ($urandom_range(0, 3) == 0);
                    end
                endcase
                step();
                if ($urandom_range(0, 999) == 0)
                    async_reset_check();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
